// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file:
//   - default data width and depth
//   - state encoding of the bulk-clear engine
//   - clog2 helper used to derive address widths from DEPTH
// No ports; imported by regfile_clear_fsm and regfile_mp.
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEFAULT_DW    = 32;
   localparam int DEFAULT_DEPTH = 32;

   typedef enum logic {
      IDLE,
      CLEAR
   } clr_state_e;

   // Smallest n such that 2**n >= value; written as a bounded loop so it
   // stays a constant function for parameter elaboration.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// ---------------------------------------------------------------------------
// regfile_clear_fsm
// Sequencer for the bulk-clear engine of regfile_mp. Walks an index from 0 to
// DEPTH-1, one entry per clock, and reports busy while doing so.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   clear_req_i  level-sampled clear request (ignored while busy)
//   wr_req_i     any write port enabled this cycle (used for drop detect)
//   busy_o       high while the clear walk is running (exactly DEPTH cycles)
//   clear_done_o one-cycle pulse after the last entry has been cleared
//   wr_drop_o    one-cycle pulse after a cycle in which a write hit busy
//   idx_o        entry being cleared on the coming edge
// ---------------------------------------------------------------------------
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_req_i,
   input  logic          wr_req_i,
   output logic          busy_o,
   output logic          clear_done_o,
   output logic          wr_drop_o,
   output logic [AW-1:0] idx_o
);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          done_q, done_d;
   logic          drop_q, drop_d;

   // State, index and the two registered pulses; reset returns to IDLE
   // without ever producing a done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

   // Next-state logic. The done pulse is registered on the same edge that
   // clears the last entry, so it appears in the first idle cycle; a request
   // still held in that cycle restarts the walk immediately.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      drop_d  = (state_q == CLEAR) && wr_req_i;
      case (state_q)
         IDLE: begin
            if (clear_req_i) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            if (idx_q == AW'(DEPTH - 1)) begin
               state_d = IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign busy_o       = (state_q == CLEAR);
   assign clear_done_o = done_q;
   assign wr_drop_o    = drop_q;
   assign idx_o        = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised register file: NUM_RD combinational read ports, two write
// ports (port 1 wins on an address collision) and a sequential bulk clear.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle forwarding of
// accepted write data to matching read ports.
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-low reset
//   rd_addr / rd_data      packed read ports, port k at [k*AW +: AW] / [k*DW +: DW]
//   we0/waddr0/wdata0      write port 0
//   we1/waddr1/wdata1      write port 1 (higher priority)
//   clear_req              bulk-clear request
//   busy, clear_done       clear engine status
//   wr_drop                pulse after a write was discarded during busy
// ---------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int DW       = DEFAULT_DW,
   parameter  int DEPTH    = DEFAULT_DEPTH,
   parameter  int NUM_RD   = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   input  logic                 we0,
   input  logic [AW-1:0]        waddr0,
   input  logic [DW-1:0]        wdata0,
   input  logic                 we1,
   input  logic [AW-1:0]        waddr1,
   input  logic [DW-1:0]        wdata1,
   input  logic                 clear_req,
   output logic                 busy,
   output logic                 clear_done,
   output logic                 wr_drop
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] clearIdx;
   logic          wrAcc0;
   logic          wrAcc1;

   regfile_clear_fsm #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear_fsm (
      .clk          (clk),
      .rst          (rst),
      .clear_req_i  (clear_req),
      .wr_req_i     (we0 | we1),
      .busy_o       (busy),
      .clear_done_o (clear_done),
      .wr_drop_o    (wr_drop),
      .idx_o        (clearIdx)
   );

   // A write is accepted only outside a clear walk; writes to entry 0 are
   // swallowed here when it is hard-wired to zero, so they never reach the
   // array or the bypass path.
   assign wrAcc0 = we0 && !busy && !((ZERO_REG != 0) && (waddr0 == '0));
   assign wrAcc1 = we1 && !busy && !((ZERO_REG != 0) && (waddr1 == '0));

   // Storage. Port 1 is assigned last so it overrides port 0 when both
   // target the same entry. While busy only the clear walk touches the array.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (busy) begin
         mem_q[clearIdx] <= '0;
      end else begin
         if (wrAcc0) begin
            mem_q[waddr0] <= wdata0;
         end
         if (wrAcc1) begin
            mem_q[waddr1] <= wdata1;
         end
      end
   end

   // Independent combinational read muxes, one per port. With forwarding
   // enabled, port 1 data is applied last so it has priority over port 0.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] rdAddr;
      logic [DW-1:0] rdVal;

      assign rdAddr = rd_addr[k*AW +: AW];

      always_comb begin
         rdVal = mem_q[rdAddr];
`ifdef REGFILE_BYPASS_EN
         if (wrAcc0 && (waddr0 == rdAddr)) begin
            rdVal = wdata0;
         end
         if (wrAcc1 && (waddr1 == rdAddr)) begin
            rdVal = wdata1;
         end
`else
`endif
         if ((ZERO_REG != 0) && (rdAddr == '0)) begin
            rdVal = '0;
         end
      end

      assign rd_data[k*DW +: DW] = rdVal;
   end

endmodule
